// File: rtl/pipe_pkg.sv
// Shared pipeline types: ALU op classes, the packed control bundle and default widths.
package pipe_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_REG_ADDR_W = 5;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   typedef struct packed {
      logic       reg_dst;
      logic       branch;
      logic       mem_read;
      logic       mem_to_reg;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic [1:0] alu_op;
   } ctrl_t;

   // A bubble is an all-zero control word, which also selects ALUOP_ADD.
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by the ID instruction.
module load_use_detect
   import pipe_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic                  ex_valid,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_reg_dst,
   input  logic                  id_mem_write,
   input  logic                  id_branch,
   output logic                  load_use
);

   logic rt_is_source;

   // rt is only a source operand for R-type, store and branch instructions.
   assign rt_is_source = id_reg_dst | id_mem_write | id_branch;

   assign load_use = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                     ((ex_rt == id_rs) | ((ex_rt == id_rt) & rt_is_source));

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, external hold and branch flush.
// Optional macro ID_EX_PERF_CNT_EN adds perf_bubbles / perf_holds counters.
module id_ex_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  ext_stall,
   input  logic                  id_valid,
   input  logic                  id_reg_dst,
   input  logic                  id_branch,
   input  logic                  id_mem_read,
   input  logic                  id_mem_to_reg,
   input  logic                  id_mem_write,
   input  logic                  id_alu_src,
   input  logic                  id_reg_write,
   input  logic [1:0]            id_alu_op,
   input  logic [DATA_W-1:0]     id_rd1,
   input  logic [DATA_W-1:0]     id_rd2,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [DATA_W-1:0]     id_pc_plus4,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [5:0]            id_funct,
   output logic                  ex_valid,
   output logic                  ex_reg_dst,
   output logic                  ex_branch,
   output logic                  ex_mem_read,
   output logic                  ex_mem_to_reg,
   output logic                  ex_mem_write,
   output logic                  ex_alu_src,
   output logic                  ex_reg_write,
   output logic [1:0]            ex_alu_op,
   output logic [DATA_W-1:0]     ex_rd1,
   output logic [DATA_W-1:0]     ex_rd2,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [DATA_W-1:0]     ex_pc_plus4,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [5:0]            ex_funct,
   output logic                  hazard_stall
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0]           perf_bubbles,
   output logic [31:0]           perf_holds
`endif
);

   ctrl_t id_ctrl;
   ctrl_t ex_ctrl;
   logic  load_use;
   logic  do_load;
   logic  do_bubble;

   assign id_ctrl = {id_reg_dst, id_branch, id_mem_read, id_mem_to_reg,
                     id_mem_write, id_alu_src, id_reg_write, id_alu_op};

   load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
      .ex_valid     (ex_valid),
      .ex_mem_read  (ex_ctrl.mem_read),
      .ex_rt        (ex_rt),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_reg_dst   (id_reg_dst),
      .id_mem_write (id_mem_write),
      .id_branch    (id_branch),
      .load_use     (load_use)
   );

   // Stall still asserts during ext_stall so upstream stays frozen behind the held EX slot.
   assign hazard_stall = load_use & ~flush & ~reset;

   // ex_valid marks a real instruction in EX; a bubble has ex_valid=0 and zero control,
   // while its data/index fields are don't-care and simply follow id_*.
   assign do_load   = flush | ~ext_stall;
   assign do_bubble = flush | load_use;

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid    <= 1'b0;
         ex_ctrl     <= CTRL_BUBBLE;
         ex_rd1      <= '0;
         ex_rd2      <= '0;
         ex_imm      <= '0;
         ex_pc_plus4 <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
         ex_funct    <= '0;
      end else if (do_load) begin
         ex_valid    <= id_valid & ~do_bubble;
         ex_ctrl     <= do_bubble ? CTRL_BUBBLE : id_ctrl;
         ex_rd1      <= id_rd1;
         ex_rd2      <= id_rd2;
         ex_imm      <= id_imm;
         ex_pc_plus4 <= id_pc_plus4;
         ex_rs       <= id_rs;
         ex_rt       <= id_rt;
         ex_rd       <= id_rd;
         ex_funct    <= id_funct;
      end
   end

   assign ex_reg_dst    = ex_ctrl.reg_dst;
   assign ex_branch     = ex_ctrl.branch;
   assign ex_mem_read   = ex_ctrl.mem_read;
   assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
   assign ex_mem_write  = ex_ctrl.mem_write;
   assign ex_alu_src    = ex_ctrl.alu_src;
   assign ex_reg_write  = ex_ctrl.reg_write;
   assign ex_alu_op     = ex_ctrl.alu_op;

`ifdef ID_EX_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_bubbles <= '0;
         perf_holds   <= '0;
      end else begin
         if (!flush && !ext_stall && load_use)
            perf_bubbles <= perf_bubbles + 32'd1;
         if (!flush && ext_stall)
            perf_holds <= perf_holds + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: stimulus pushes expected EX state, a monitor pops and compares.
// Build with ID_EX_PERF_CNT_EN defined to also check the perf counters.
module tb_id_ex_stage_reg;

   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct packed {
      logic          care;
      logic          valid;
      logic [8:0]    ctrl;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic [DW-1:0] imm;
      logic [DW-1:0] pc;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] rd;
      logic [5:0]    funct;
      logic [31:0]   pb;
      logic [31:0]   ph;
   } exp_t;
   localparam int EW = $bits(exp_t);

   logic clk = 1'b1;
   logic reset, flush, ext_stall, id_valid;
   logic id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;
   logic [1:0] id_alu_op;
   logic [DW-1:0] id_rd1, id_rd2, id_imm, id_pc_plus4;
   logic [AW-1:0] id_rs, id_rt, id_rd;
   logic [5:0] id_funct;
   logic ex_valid, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
   logic [1:0] ex_alu_op;
   logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc_plus4;
   logic [AW-1:0] ex_rs, ex_rt, ex_rd;
   logic [5:0] ex_funct;
   logic hazard_stall;
   logic [31:0] act_pb, act_ph;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] perf_bubbles, perf_holds;
   assign act_pb = perf_bubbles;
   assign act_ph = perf_holds;
`else
   assign act_pb = '0;
   assign act_ph = '0;
`endif

   id_ex_stage_reg #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .flush(flush), .ext_stall(ext_stall), .id_valid(id_valid),
      .id_reg_dst(id_reg_dst), .id_branch(id_branch), .id_mem_read(id_mem_read),
      .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
      .id_reg_write(id_reg_write), .id_alu_op(id_alu_op), .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_imm(id_imm), .id_pc_plus4(id_pc_plus4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_funct(id_funct), .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch),
      .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
      .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
      .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc_plus4(ex_pc_plus4),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
      .hazard_stall(hazard_stall)
`ifdef ID_EX_PERF_CNT_EN
      , .perf_bubbles(perf_bubbles), .perf_holds(perf_holds)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];
   logic          hz_q[$];

   // reference model of what EX should hold; bubbles leave data as don't-care
   exp_t m;

   function automatic logic [8:0] id_ctrl_vec();
      return {id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
              id_alu_src, id_reg_write, id_alu_op};
   endfunction

   // issue the current inputs: predict hazard_stall and the state after the next edge
   task automatic step();
      logic lu, uses_rt;
      exp_t n;
      uses_rt = id_reg_dst | id_mem_write | id_branch;
      lu = m.valid && m.ctrl[6] && (m.rt != 0) && id_valid &&
           ((m.rt == id_rs) || ((m.rt == id_rt) && uses_rt));
      hz_q.push_back(lu && !flush && !reset);
      n = m;
      if (reset) begin
         n = '0;
         n.care = 1'b1;
      end else if (flush || !ext_stall) begin
         n.rd1 = id_rd1; n.rd2 = id_rd2; n.imm = id_imm; n.pc = id_pc_plus4;
         n.rs = id_rs; n.rt = id_rt; n.rd = id_rd; n.funct = id_funct;
         if (flush || lu) begin
            n.valid = 1'b0; n.ctrl = '0; n.care = 1'b0;
            if (!flush) n.pb = m.pb + 1;
         end else begin
            n.valid = id_valid; n.ctrl = id_ctrl_vec(); n.care = 1'b1;
         end
      end else begin
         n.ph = m.ph + 1;
      end
      m = n;
      exp_q.push_back(n);
      @(posedge clk);
      #1;
   endtask

   // driver tasks
   task automatic clear_inputs();
      {reset, flush, ext_stall, id_valid} = '0;
      {id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write} = '0;
      id_alu_op = 2'b00;
      id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom; id_pc_plus4 = $urandom;
      id_rs = AW'($urandom_range(1, 31)); id_rt = AW'($urandom_range(1, 31));
      id_rd = AW'($urandom); id_funct = 6'($urandom);
   endtask

   task automatic rand_inputs();
      clear_inputs();
      reset     = ($urandom_range(0, 49) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      ext_stall = ($urandom_range(0, 5) == 0);
      id_valid  = ($urandom_range(0, 7) != 0);
      {id_reg_dst, id_branch, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write} = 6'($urandom);
      id_mem_read = $urandom_range(0, 1);
      id_alu_op = 2'($urandom_range(0, 2));
      id_rs = AW'($urandom_range(0, 3));
      id_rt = AW'($urandom_range(0, 3));
   endtask

   task automatic load_word(input logic [AW-1:0] rt);
      clear_inputs();
      id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1; id_alu_src = 1; id_rt = rt;
   endtask

   task automatic rtype(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
      clear_inputs();
      id_valid = 1; id_reg_write = 1; id_reg_dst = 1; id_alu_op = 2'b10; id_rs = rs; id_rt = rt;
   endtask

   // scoreboard monitor
   initial begin : monitor
      exp_t e, a;
      logic eh;
      forever begin
         @(negedge clk);
         if (hz_q.size() > 0) begin
            eh = hz_q.pop_front();
            checks++;
            if (hazard_stall !== eh) begin
               errors++;
               $display("FAIL hazard_stall t=%0t act=%0b exp=%0b", $time, hazard_stall, eh);
            end
         end
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '0;
            a.valid = ex_valid;
            a.ctrl = {ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
                      ex_alu_src, ex_reg_write, ex_alu_op};
            a.rd1 = ex_rd1; a.rd2 = ex_rd2; a.imm = ex_imm; a.pc = ex_pc_plus4;
            a.rs = ex_rs; a.rt = ex_rt; a.rd = ex_rd; a.funct = ex_funct;
            checks++;
            if (e.care) begin
               if ({a.valid, a.ctrl, a.rd1, a.rd2, a.imm, a.pc, a.rs, a.rt, a.rd, a.funct} !==
                   {e.valid, e.ctrl, e.rd1, e.rd2, e.imm, e.pc, e.rs, e.rt, e.rd, e.funct}) begin
                  errors++;
                  $display("FAIL ex_regs t=%0t act v=%0b c=%h rd1=%h rd2=%h imm=%h pc=%h rs=%0d rt=%0d rd=%0d f=%h exp v=%0b c=%h rd1=%h rd2=%h imm=%h pc=%h rs=%0d rt=%0d rd=%0d f=%h",
                           $time, a.valid, a.ctrl, a.rd1, a.rd2, a.imm, a.pc, a.rs, a.rt, a.rd, a.funct,
                           e.valid, e.ctrl, e.rd1, e.rd2, e.imm, e.pc, e.rs, e.rt, e.rd, e.funct);
               end
            end else if ({a.valid, a.ctrl} !== {e.valid, e.ctrl}) begin
               errors++;
               $display("FAIL ex_bubble t=%0t act v=%0b c=%h exp v=%0b c=%h",
                        $time, a.valid, a.ctrl, e.valid, e.ctrl);
            end
`ifdef ID_EX_PERF_CNT_EN
            checks++;
            if ({act_pb, act_ph} !== {e.pb, e.ph}) begin
               errors++;
               $display("FAIL perf t=%0t act bubbles=%0d holds=%0d exp bubbles=%0d holds=%0d",
                        $time, act_pb, act_ph, e.pb, e.ph);
            end
`endif
         end
      end
   end

   // stimulus
   initial begin : stimulus
      m = '0;
      clear_inputs();
      // reset then R-type pass-through
      reset = 1; step();
      reset = 1; step();
      rtype(5'd1, 5'd2); id_rd1 = 32'h5; id_rd2 = 32'h3; id_rd = 5'd8; step();
      // load-use: one bubble, then the held add advances
      load_word(5'd9); step();
      rtype(5'd9, 5'd4); step();
      rtype(5'd9, 5'd4); step();
      // no false hazards: rt=0, and addi reading rt only as a destination
      load_word(5'd0); step();
      rtype(5'd0, 5'd0); step();
      load_word(5'd9); step();
      clear_inputs(); id_valid = 1; id_alu_src = 1; id_reg_write = 1; id_rs = 5'd1; id_rt = 5'd9; step();
      // flush beats ext_stall and load_use
      load_word(5'd9); step();
      rtype(5'd9, 5'd9); flush = 1; ext_stall = 1; step();
      // external hold for 3 cycles, then release
      rtype(5'd1, 5'd2); id_rd1 = 32'hA; step();
      for (int i = 0; i < 3; i++) begin
         rand_inputs(); reset = 0; flush = 0; ext_stall = 1; step();
      end
      rtype(5'd3, 5'd4); step();
      // second load-use bubble for the counters
      load_word(5'd7); step();
      rtype(5'd7, 5'd1); step();
      rtype(5'd7, 5'd1); step();
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rand_inputs(); step();
      end
      clear_inputs(); reset = 1; step();
      clear_inputs(); step();
      // bounded drain of the scoreboard
      for (int i = 0; i < 10 && (exp_q.size() > 0 || hz_q.size() > 0); i++) @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0 || hz_q.size() != 0) begin
         errors++;
         $display("FAIL drain act=%0d pending exp=0", exp_q.size() + hz_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
